// File: rtl/pipelined_rca_if.sv
// ----------------------------------------------------------------------------
// pipelined_rca_if
// Streaming handshake bundle for the pipelined ripple-carry adder.
//   in_valid / in_ready  : operand beat handshake (a, b, cin)
//   out_valid / out_ready: result beat handshake (sum, cout)
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the adder itself
// ----------------------------------------------------------------------------
interface pipelined_rca_if #(
  parameter int Nbits = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [Nbits-1:0] a;
  logic [Nbits-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [Nbits-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/pipelined_rca.sv
// ----------------------------------------------------------------------------
// pipelined_rca
// Nbits-wide ripple-carry adder split into NSTAGES equal slices of
// W = Nbits/NSTAGES bits. Each stage ripples one slice and registers the slice
// sum and its carry, so the combinational path is W full-adder delays.
// All stages advance together (adv = out_ready | ~out_valid); bubbles move
// like data, and a stalled output freezes the whole pipe.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears valid bits and data
//   bus   : pipelined_rca_if slave modport (in_valid/in_ready/a/b/cin in,
//           out_valid/out_ready/sum/cout out)
// Parameters:
//   Nbits   : operand/sum width, multiple of NSTAGES
//   NSTAGES : pipeline depth = latency in cycles, 1..Nbits
//   signd   : 0 -> cout is the unsigned carry-out, 1 -> signed overflow
// ----------------------------------------------------------------------------
module pipelined_rca #(
  parameter int Nbits   = 8,
  parameter int NSTAGES = 2,
  parameter bit signd   = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  pipelined_rca_if.slave bus
);

  localparam int W = Nbits / NSTAGES;

  if ((NSTAGES < 1) || (NSTAGES > Nbits) || ((Nbits % NSTAGES) != 0)) begin : g_param_check
    $error("pipelined_rca: Nbits must be a multiple of NSTAGES with 1 <= NSTAGES <= Nbits");
  end

  // One-bit full adder, returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  // W-bit ripple chain built from full_add, returns {carry_out, sum}.
  function automatic logic [W:0] ripple(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c);
    logic [W:0] r;
    logic       carry;
    logic [1:0] fa;
    r     = '0;
    carry = c;
    for (int i = 0; i < W; i++) begin
      fa    = full_add(x[i], y[i], carry);
      r[i]  = fa[0];
      carry = fa[1];
    end
    r[W] = carry;
    return r;
  endfunction

  logic adv;

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    // Operand bits that have not been added yet when a beat enters stage k;
    // bit 0 of op_a/op_b is original bit k*W.
    localparam int IW = Nbits - k * W;

    logic [IW-1:0]      op_a;
    logic [IW-1:0]      op_b;
    logic               c_in;
    logic               v_in;
    logic [W:0]         slice;
    logic [(k+1)*W-1:0] sum_next;
    logic [(k+1)*W-1:0] sum_r;
    logic               valid_r;

    if (k == 0) begin : g_head
      assign op_a     = bus.a;
      assign op_b     = bus.b;
      assign c_in     = bus.cin;
      assign v_in     = bus.in_valid;
      assign sum_next = slice[W-1:0];
    end else begin : g_body
      assign op_a     = g_stage[k-1].g_fwd.a_r;
      assign op_b     = g_stage[k-1].g_fwd.b_r;
      assign c_in     = g_stage[k-1].g_fwd.carry_r;
      assign v_in     = g_stage[k-1].valid_r;
      // Newly computed slice sits above the sum bits finished upstream.
      assign sum_next = {slice[W-1:0], g_stage[k-1].sum_r};
    end

    assign slice = ripple(op_a[W-1:0], op_b[W-1:0], c_in);

    // Stage valid bit and the accumulated low sum bits.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        sum_r   <= '0;
      end else if (adv) begin
        valid_r <= v_in;
        sum_r   <= sum_next;
      end
    end

    if (k < NSTAGES - 1) begin : g_fwd
      // Only the operand bits still to be added travel on; the top bit of
      // each operand reaches the last stage for the overflow flag.
      logic [IW-W-1:0] a_r;
      logic [IW-W-1:0] b_r;
      logic            carry_r;

      // Forwarded operand bits and slice carry.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r     <= '0;
          b_r     <= '0;
          carry_r <= 1'b0;
        end else if (adv) begin
          a_r     <= op_a[IW-1:W];
          b_r     <= op_b[IW-1:W];
          carry_r <= slice[W];
        end
      end
    end else begin : g_last
      logic cout_next;
      logic cout_r;

      // Last slice holds bit Nbits-1: choose carry-out or signed overflow.
      always_comb begin
        if (signd) begin
          cout_next = (~op_a[W-1] & ~op_b[W-1] &  slice[W-1]) |
                      ( op_a[W-1] &  op_b[W-1] & ~slice[W-1]);
        end else begin
          cout_next = slice[W];
        end
      end

      // Registered cout, held with the rest of the pipe on a stall.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cout_r <= 1'b0;
        end else if (adv) begin
          cout_r <= cout_next;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NSTAGES-1].valid_r;
  assign bus.sum       = g_stage[NSTAGES-1].sum_r;
  assign bus.cout      = g_stage[NSTAGES-1].g_last.cout_r;

endmodule

// File: tb/tb_pipelined_rca.sv
// ----------------------------------------------------------------------------
// tb_pipelined_rca
// Two 8-bit/2-stage adders (unsigned and signed flag) share one stimulus
// stream; six 16-bit adders (NSTAGES 1, 4, 16 in both cout modes) share a
// second stream. Expected results are queued when a beat is accepted and
// compared when the adder presents it.
// ----------------------------------------------------------------------------
module tb_pipelined_rca;

  typedef struct {
    logic [7:0] s;
    logic       cu;
    logic       cs;
  } exp8_t;

  typedef struct {
    int          t;
    logic [15:0] s;
    logic        cu;
    logic        cs;
  } exp16_t;

  logic clk;
  logic rst_n;

  logic       in_valid8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       out_ready8;

  logic        in_valid16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;

  logic [5:0]    v16;
  logic [5:0]    c16;
  logic [5:0]    r16;
  logic [95:0]   s16;

  int     nchk;
  int     nfail;
  logic   [1:0] mv;
  exp8_t  q8[$];
  exp16_t q16[$];
  int     rd[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_rca_if #(.Nbits(8)) if8u ();
  pipelined_rca_if #(.Nbits(8)) if8s ();

  assign if8u.in_valid  = in_valid8;
  assign if8u.a         = a8;
  assign if8u.b         = b8;
  assign if8u.cin       = cin8;
  assign if8u.out_ready = out_ready8;
  assign if8s.in_valid  = in_valid8;
  assign if8s.a         = a8;
  assign if8s.b         = b8;
  assign if8s.cin       = cin8;
  assign if8s.out_ready = out_ready8;

  pipelined_rca #(.Nbits(8), .NSTAGES(2), .signd(1'b0)) dut8u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8u)
  );

  pipelined_rca #(.Nbits(8), .NSTAGES(2), .signd(1'b1)) dut8s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8s)
  );

  for (genvar g = 0; g < 6; g++) begin : g_sweep
    pipelined_rca_if #(.Nbits(16)) bif ();

    assign bif.in_valid  = in_valid16;
    assign bif.a         = a16;
    assign bif.b         = b16;
    assign bif.cin       = cin16;
    assign bif.out_ready = 1'b1;

    assign v16[g]          = bif.out_valid;
    assign c16[g]          = bif.cout;
    assign r16[g]          = bif.in_ready;
    assign s16[g*16 +: 16] = bif.sum;

    pipelined_rca #(
      .Nbits   (16),
      .NSTAGES ((g < 2) ? 1 : ((g < 4) ? 4 : 16)),
      .signd   ((g % 2) == 1)
    ) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
    );
  end

  function automatic int lat16(input int d);
    return (d < 2) ? 1 : ((d < 4) ? 4 : 16);
  endfunction

  function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    exp8_t e;
    int    u;
    int    s;
    u    = int'(x) + int'(y) + int'(c);
    s    = int'($signed(x)) + int'($signed(y)) + int'(c);
    e.s  = 8'(u);
    e.cu = (u > 255);
    e.cs = (s > 127) || (s < -128);
    return e;
  endfunction

  function automatic exp16_t model16(input int t, input logic [15:0] x, input logic [15:0] y,
                                     input logic c);
    exp16_t e;
    int     u;
    int     s;
    u    = int'(x) + int'(y) + int'(c);
    s    = int'($signed(x)) + int'($signed(y)) + int'(c);
    e.t  = t;
    e.s  = 16'(u);
    e.cu = (u > 65535);
    e.cs = (s > 32767) || (s < -32768);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle of the 8-bit stream: called at a negedge, checks the outputs
  // against the bench model, drives the next inputs, advances the model.
  task automatic step8(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic ordy, input logic rstv);
    logic adv;
    chk("out_valid_u", 32'(if8u.out_valid), 32'(mv[1]));
    chk("out_valid_s", 32'(if8s.out_valid), 32'(mv[1]));
    if (mv[1]) begin
      chk("sum_u",  32'(if8u.sum),  32'(q8[0].s));
      chk("sum_s",  32'(if8s.sum),  32'(q8[0].s));
      chk("cout_u", 32'(if8u.cout), 32'(q8[0].cu));
      chk("ovf_s",  32'(if8s.cout), 32'(q8[0].cs));
    end
    in_valid8  = iv;
    a8         = av;
    b8         = bv;
    cin8       = cv;
    out_ready8 = ordy;
    rst_n      = rstv;
    #1;
    adv = ordy | ~mv[1];
    chk("in_ready_u", 32'(if8u.in_ready), 32'(adv));
    chk("in_ready_s", 32'(if8s.in_ready), 32'(adv));
    if (!rstv) begin
      mv = 2'b00;
      q8.delete();
    end else if (adv) begin
      if (mv[1]) begin
        void'(q8.pop_front());
      end
      mv[1] = mv[0];
      mv[0] = iv;
      if (iv) begin
        q8.push_back(model8(av, bv, cv));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    nchk       = 0;
    nfail      = 0;
    mv         = 2'b00;
    rst_n      = 1'b0;
    in_valid8  = 1'b0;
    a8         = 8'h00;
    b8         = 8'h00;
    cin8       = 1'b0;
    out_ready8 = 1'b0;
    in_valid16 = 1'b0;
    a16        = 16'h0000;
    b16        = 16'h0000;
    cin16      = 1'b0;
    for (int d = 0; d < 6; d++) rd[d] = 0;

    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out_valid_u", 32'(if8u.out_valid), 32'd0);
    chk("rst_out_valid_s", 32'(if8s.out_valid), 32'd0);
    chk("rst_sum_u",       32'(if8u.sum),       32'd0);
    chk("rst_cout_u",      32'(if8u.cout),      32'd0);
    chk("rst_cout_s",      32'(if8s.cout),      32'd0);
    chk("rst_in_ready_u",  32'(if8u.in_ready),  32'd1);
    chk("rst_valid16",     32'(v16),            32'd0);

    // Directed vectors with gaps: carry across the slice boundary and the
    // signed-overflow corners.
    step8(1'b1, 8'hC8, 8'h64, 1'b0, 1'b1, 1'b1);
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    step8(1'b1, 8'h0F, 8'h00, 1'b1, 1'b1, 1'b1);
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    step8(1'b1, 8'h64, 8'h32, 1'b0, 1'b1, 1'b1);
    step8(1'b1, 8'h80, 8'hFF, 1'b0, 1'b1, 1'b1);
    step8(1'b1, 8'h7F, 8'h80, 1'b0, 1'b1, 1'b1);
    step8(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    repeat (3) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      step8(1'b1, 8'(i), 8'h10, 1'b0, 1'b1, 1'b1);
    end
    repeat (3) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);

    // Backpressure: fill, stall 3 cycles with a beat offered, then drain
    step8(1'b1, 8'h21, 8'h13, 1'b0, 1'b1, 1'b1);
    step8(1'b1, 8'h35, 8'h44, 1'b1, 1'b1, 1'b1);
    repeat (3) step8(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
    step8(1'b1, 8'h99, 8'h01, 1'b0, 1'b1, 1'b1);
    repeat (4) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);

    // Random valid/ready traffic
    for (int i = 0; i < 60; i++) begin
      step8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b1);
    end
    repeat (4) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);

    // Reset with two beats in flight
    step8(1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1);
    step8(1'b1, 8'h33, 8'h44, 1'b1, 1'b1, 1'b1);
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("midrst_out_valid_u", 32'(if8u.out_valid), 32'd0);
    chk("midrst_out_valid_s", 32'(if8s.out_valid), 32'd0);
    chk("midrst_sum_u",       32'(if8u.sum),       32'd0);
    chk("midrst_sum_s",       32'(if8s.sum),       32'd0);
    chk("midrst_cout_u",      32'(if8u.cout),      32'd0);
    chk("midrst_cout_s",      32'(if8s.cout),      32'd0);
    repeat (4) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);

    // 16-bit sweep: random beats with bubbles, out_ready tied high
    for (int t = 0; t < 90; t++) begin
      for (int d = 0; d < 6; d++) begin
        chk("in_ready16", 32'(r16[d]), 32'd1);
        if (v16[d]) begin
          if (rd[d] < q16.size()) begin
            chk($sformatf("latency16_d%0d", d), 32'(t), 32'(q16[rd[d]].t + lat16(d)));
            chk($sformatf("sum16_d%0d", d), 32'(s16[d*16 +: 16]), 32'(q16[rd[d]].s));
            chk($sformatf("cout16_d%0d", d), 32'(c16[d]),
                32'(((d % 2) == 1) ? q16[rd[d]].cs : q16[rd[d]].cu));
            rd[d]++;
          end else begin
            chk($sformatf("extra16_d%0d", d), 32'(v16[d]), 32'd0);
          end
        end
      end
      in_valid16 = (t < 60) && ($urandom_range(0, 3) != 0);
      a16        = 16'($urandom);
      b16        = 16'($urandom);
      cin16      = 1'($urandom_range(0, 1));
      if (t == 3) begin
        a16 = 16'h7FFF;
        b16 = 16'h0000;
        cin16 = 1'b1;
        in_valid16 = 1'b1;
      end
      if (t == 4) begin
        a16 = 16'hFFFF;
        b16 = 16'h0001;
        cin16 = 1'b0;
        in_valid16 = 1'b1;
      end
      if (in_valid16) begin
        q16.push_back(model16(t, a16, b16, cin16));
      end
      @(negedge clk);
    end
    for (int d = 0; d < 6; d++) begin
      chk($sformatf("count16_d%0d", d), 32'(rd[d]), 32'(q16.size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
